rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Two-source round-robin arbiter that sequences an 8-bit 2:1 select datapath. It shares one downstream consumer between source A and source B using valid/ready handshakes on every port. It drives the select from a fair rotating priority and registers the chosen byte in a one-entry output stage. It sits between two byte producers and a single consumer in the datapath.

## Interface
- DATA_W, 8, width of each data path
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- a_data  input  DATA_W  source A byte
- a_valid  input  1  source A offers a_data
- a_ready  output  1  source A beat accepted this cycle
- b_data  input  DATA_W  source B byte
- b_valid  input  1  source B offers b_data
- b_ready  output  1  source B beat accepted this cycle
- o_data  output  DATA_W  registered selected byte
- o_valid  output  1  o_data holds a beat
- o_ready  input  1  consumer takes o_data this cycle
- sel  output  1  current grant, 0 = A, 1 = B, valid when a_ready|b_ready
- a_last, b_last  input  1 each  end-of-packet marks, present only with LOCK_EN

## Operation
- Beat transfer on a port: valid & ready high at the same rising edge.
- load = ~o_valid | o_ready: the output stage can take a new beat this cycle.
- Grant, combinational:
  - Only one source valid: that source wins.
  - Both valid: the source not granted last wins. The priority pointer prio holds the last winner, 0 = A.
  - Neither valid: sel holds prio, and there is no grant.
- a_ready = load & grant==A & a_valid. b_ready is analogous. Never both high.
- Accept: o_data <= winner data, o_valid <= 1, prio <= winner.
- Drain without accept: o_valid & o_ready & no grant sets o_valid <= 0.
- Simultaneous drain and accept: o_valid stays 1 and o_data is replaced. Full throughput is one beat per cycle.
- Stall: o_valid & ~o_ready holds o_data and o_valid stable, and both readys are 0.
- Sources may drop valid without a transfer. Arbitration is re-evaluated every cycle with no lock-in, unless LOCK_EN is defined.
- State machine, 2 states:
  - EMPTY: o_valid=0. Goes to FULL on accept.
  - FULL: o_valid=1. Goes to EMPTY on o_ready with no accept. Stays in FULL on stall or on drain+accept.

## Timing
- Reset values: o_valid=0, o_data=0, prio=0 (so B wins the first contention), sel=0, a_ready=0, b_ready=0, state EMPTY. Locked flag=0 when LOCK_EN is defined.
- rst during FULL discards the held beat. No transfer is reported in the reset cycle.
- Latency: a beat accepted at edge N appears on o_data/o_valid after edge N. It can be consumed at edge N+1.
- a_ready and b_ready depend combinationally on o_ready and the valid inputs. There is no combinational path from any input to o_data or o_valid.
- With continuous contention and o_ready=1, output order is B,A,B,A,…

## Configuration
- LOCK_EN defined:
  - a_last and b_last ports exist.
  - After a winner's beat is accepted with last=0, the grant is locked to that source.
  - While locked, the other source is never granted, even if the locked source drops valid.
  - The lock releases on the accepted beat with last=1. prio updates then.
- LOCK_EN undefined:
  - The ports are absent and arbitration is per beat.

## Structure
- Shared package rr_mux_pkg holds:
  - DATA_W default
  - the state encoding constants ST_EMPTY and ST_FULL
  - the grant encoding GNT_A=0 and GNT_B=1
- One sub-module, rr_arb2: the combinational grant plus the prio register (and the lock register under LOCK_EN). The top holds the select datapath and the output stage.

## Test plan
- Reset, then a_valid=1 with a_data=8'h11 and o_ready=1 -> a_ready=1 in the same cycle. o_data=8'h11 and o_valid=1 the next cycle.
- Both valid continuously, a_data=8'hAA, b_data=8'hBB, o_ready=1 -> o_data sequence BB,AA,BB,AA with one beat per cycle.
- o_ready=0 with o_valid=1 for 3 cycles, both sources valid -> readys stay 0 and o_data unchanged. On o_ready=1, the pending winner loads in the same cycle.
- Assert rst with o_valid=1 and o_data=8'h5C -> the next cycle o_valid=0 and o_data=0. Afterwards the first contention grants B.
- Only B valid for 4 beats (8'h01–8'h04), then both valid -> B streams uninterrupted, then A wins the first contention.
- LOCK_EN: A sends 3 beats with last on the third while B stays valid -> output A,A,A,B.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
// Optional packet lock is enabled by defining LOCK_EN.
package rr_mux_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with last-winner priority register.
// With LOCK_EN defined, the grant sticks to a source until its last beat is accepted.
module rr_arb2
    import rr_mux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_a_valid,
    input  logic i_b_valid,
`ifdef LOCK_EN
    input  logic i_a_last,
    input  logic i_b_last,
`endif
    input  logic i_load,
    output logic o_a_ready,
    output logic o_b_ready,
    output logic o_sel
);

    logic r_prio;
    logic w_sel;
    logic w_gnt;
    logic w_accept;
    logic w_locked;

`ifdef LOCK_EN
    logic r_locked;
    logic w_last;

    assign w_locked = r_locked;
    assign w_last   = (w_sel == GNT_B) ? i_b_last : i_a_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else if (w_accept) begin
            r_locked <= ~w_last;
        end
    end
`else
    assign w_locked = 1'b0;
`endif

    always_comb begin
        w_sel = r_prio;
        w_gnt = 1'b0;
        if (w_locked) begin
            // prio tracks every accepted winner, so it also names the locked source
            w_sel = r_prio;
            w_gnt = (r_prio == GNT_B) ? i_b_valid : i_a_valid;
        end else if (i_a_valid && i_b_valid) begin
            w_sel = ~r_prio;
            w_gnt = 1'b1;
        end else if (i_a_valid) begin
            w_sel = GNT_A;
            w_gnt = 1'b1;
        end else if (i_b_valid) begin
            w_sel = GNT_B;
            w_gnt = 1'b1;
        end
        if (rst) begin
            w_sel = GNT_A;
            w_gnt = 1'b0;
        end
    end

    assign o_a_ready = i_load & w_gnt & (w_sel == GNT_A);
    assign o_b_ready = i_load & w_gnt & (w_sel == GNT_B);
    assign o_sel     = w_sel;
    assign w_accept  = o_a_ready | o_b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= GNT_A;
        end else if (w_accept) begin
            r_prio <= w_sel;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 2:1 byte mux with a one-entry registered output stage.
// Define LOCK_EN to add a_last/b_last and hold the grant for a whole packet.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int unsigned DATA_W = rr_mux_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
`ifdef LOCK_EN
    input  logic              a_last,
    input  logic              b_last,
`endif
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              sel
);

    state_e            r_state;
    state_e            w_state_next;
    logic [DATA_W-1:0] r_data;
    logic              w_load;
    logic              w_accept;

    assign w_load = ~o_valid | o_ready;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_a_valid (a_valid),
        .i_b_valid (b_valid),
`ifdef LOCK_EN
        .i_a_last  (a_last),
        .i_b_last  (b_last),
`endif
        .i_load    (w_load),
        .o_a_ready (a_ready),
        .o_b_ready (b_ready),
        .o_sel     (sel)
    );

    assign w_accept = a_ready | b_ready;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
            ST_FULL:  if (o_ready && !w_accept) w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_data <= (sel == GNT_B) ? b_data : a_data;
            end
        end
    end

    assign o_valid = (r_state == ST_FULL);
    assign o_data  = r_data;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed, table-driven bench for rr_mux_arbiter; the lock sequence runs only with LOCK_EN.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [7:0] o_data;
    logic       o_valid, o_ready, sel;
`ifdef LOCK_EN
    logic       a_last, b_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
`ifdef LOCK_EN
        .a_last  (a_last),
        .b_last  (b_last),
`endif
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .sel     (sel)
    );

    typedef struct packed {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       ordy;
        logic       ear;
        logic       ebr;
        logic       esel;
        logic       eov;
        logic [7:0] eod;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic av, logic [7:0] ad, logic bv, logic [7:0] bd, logic ordy,
                                logic ear, logic ebr, logic esel, logic eov, logic [7:0] eod);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
        v.ear = ear; v.ebr = ebr; v.esel = esel; v.eov = eov; v.eod = eod;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are applied 1 time unit after a posedge; comb outputs checked 1 unit later,
    // registered outputs 1 unit after the following posedge.
    task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                         input logic [7:0] bd, input logic ordy);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; o_ready = ordy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef LOCK_EN
        a_last = 1'b0;
        b_last = 1'b0;
`endif
        step();
        step();
        chk("reset_o_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_o_data", {24'd0, o_data}, 32'd0);
        chk("reset_sel", {31'd0, sel}, 32'd0);
        chk("reset_readys", {30'd0, a_ready, b_ready}, 32'd0);
        rst = 1'b0;

        //         av    ad     bv    bd     ordy  ar    br    sel   ov    od
        vecs[0]  = mk(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
        vecs[1]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBB);
        vecs[2]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
        vecs[3]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBB);
        vecs[4]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
        vecs[5]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        vecs[6]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        vecs[7]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        vecs[8]  = mk(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBB);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hBB);
        vecs[10] = mk(1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
        vecs[11] = mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02);
        vecs[12] = mk(1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04);
        vecs[14] = mk(1'b1, 8'hAA, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
        vecs[15] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA);
        vecs[16] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
        vecs[17] = mk(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].ear});
            chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].ebr});
            chk($sformatf("v%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].esel});
            step();
            chk($sformatf("v%0d_o_valid", i), {31'd0, o_valid}, {31'd0, vecs[i].eov});
            chk($sformatf("v%0d_o_data", i), {24'd0, o_data}, {24'd0, vecs[i].eod});
        end

        // Reset while holding a beat discards it; first contention afterwards goes to B.
        drive(1'b1, 8'h5C, 1'b0, 8'h00, 1'b1);
        step();
        chk("pre_rst_o_data", {24'd0, o_data}, 32'h5C);
        rst = 1'b1;
        #1;
        chk("rst_cycle_readys", {30'd0, a_ready, b_ready}, 32'd0);
        step();
        rst = 1'b0;
        chk("post_rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("post_rst_o_data", {24'd0, o_data}, 32'd0);
        drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        #1;
        chk("post_rst_b_ready", {31'd0, b_ready}, 32'd1);
        step();
        chk("post_rst_first_b", {24'd0, o_data}, 32'hBB);

`ifdef LOCK_EN
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        rst = 1'b0;
        // A1 alone, last=0: A accepted and lock taken.
        a_last = 1'b0;
        drive(1'b1, 8'hA1, 1'b0, 8'hB1, 1'b1);
        step();
        chk("lock_o_a1", {24'd0, o_data}, 32'hA1);
        // Both valid, A locked.
        drive(1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1);
        #1;
        chk("lock_a2_a_ready", {31'd0, a_ready}, 32'd1);
        step();
        chk("lock_o_a2", {24'd0, o_data}, 32'hA2);
        // A drops valid: B still must not be granted.
        drive(1'b0, 8'h00, 1'b1, 8'hB1, 1'b1);
        #1;
        chk("lock_gap_b_ready", {31'd0, b_ready}, 32'd0);
        step();
        chk("lock_gap_o_valid", {31'd0, o_valid}, 32'd0);
        a_last = 1'b1;
        drive(1'b1, 8'hA3, 1'b1, 8'hB1, 1'b1);
        step();
        chk("lock_o_a3", {24'd0, o_data}, 32'hA3);
        a_last = 1'b0;
        drive(1'b1, 8'hA4, 1'b1, 8'hB1, 1'b1);
        step();
        chk("lock_release_b", {24'd0, o_data}, 32'hB1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
